// File: rtl/lms_pkg.sv
// Shared types and helpers for the serial LMS adaptive filter:
// FSM state encoding, a width-parameterised saturator, a clog2 helper
// and the default data/fraction widths.
package lms_pkg;

  localparam int LMS_DW_DEFAULT   = 16;
  localparam int LMS_FRAC_DEFAULT = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILTER = 3'd1,
    ERR    = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Clamp v into the signed range of a w-bit quantity; the caller narrows the result.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lms_adapt_serial_if.sv
// Sample/result handshake and coefficient readback bus of the serial LMS filter.
// slave = the filter, master = whoever feeds samples and consumes results.
interface lms_adapt_serial_if
  import lms_pkg::*;
#(
  parameter int DW   = LMS_DW_DEFAULT,
  parameter int TAPS = 8
);
  localparam int AW = (clog2(TAPS) < 1) ? 1 : clog2(TAPS);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] d_in;
  logic signed [DW-1:0] mu_in;
  logic                 adapt_en;
  logic                 clear_w;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y_out;
  logic signed [DW-1:0] err_out;
  logic [AW-1:0]        coef_addr;
  logic signed [DW-1:0] coef_rdata;

  modport master (
    output in_valid, x_in, d_in, mu_in, adapt_en, clear_w, out_ready, coef_addr,
    input  in_ready, out_valid, y_out, err_out, coef_rdata
  );

  modport slave (
    input  in_valid, x_in, d_in, mu_in, adapt_en, clear_w, out_ready, coef_addr,
    output in_ready, out_valid, y_out, err_out, coef_rdata
  );
endinterface

// File: rtl/lms_mac_sat.sv
// Shared signed multiplier of the serial LMS filter. Provides the full-width
// product (for the filter accumulator) and the product shifted down by FRAC
// (floor) and saturated back to DW bits (for step-size and update products).
module lms_mac_sat
  import lms_pkg::*;
#(
  parameter int DW   = LMS_DW_DEFAULT,
  parameter int FRAC = LMS_FRAC_DEFAULT
) (
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  output logic signed [2*DW-1:0] prod_o,
  output logic signed [DW-1:0]   prod_sat_o
);
  localparam int PW = 2 * DW;

  // One multiply, then arithmetic shift and clamp to the DW-bit range.
  always_comb begin
    prod_o     = PW'(a_i) * PW'(b_i);
    prod_sat_o = DW'(sat(64'(prod_o >>> FRAC), DW));
  end
endmodule

// File: rtl/lms_adapt_serial.sv
// Time-multiplexed LMS adaptive FIR filter. A single multiplier (lms_mac_sat)
// is reused for TAPS filter MACs, the mu*e product and TAPS coefficient updates.
// Build option: define LMS_LEAKAGE_EN for leaky LMS (w -= w >>> LEAK_SHIFT in UPDATE).
module lms_adapt_serial
  import lms_pkg::*;
#(
  parameter int DW         = LMS_DW_DEFAULT,
  parameter int FRAC       = LMS_FRAC_DEFAULT,
  parameter int TAPS       = 8,
  parameter int LEAK_SHIFT = 8
) (
  input logic                Clk,
  input logic                Rst,
  lms_adapt_serial_if.slave  bus
);
  localparam int AW   = (clog2(TAPS) < 1) ? 1 : clog2(TAPS);
  localparam int ACCW = 2 * DW + clog2(TAPS);
  localparam int WW   = DW + 2;

  if (TAPS < 2) begin : g_bad_taps
    $error("lms_adapt_serial: TAPS must be at least 2");
  end
  if (ACCW > 64) begin : g_bad_accw
    $error("lms_adapt_serial: accumulator wider than 64 bits");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT >= DW) begin : g_bad_leak
    $error("lms_adapt_serial: LEAK_SHIFT must be in 1..DW-1");
  end

  state_e                 state_q, state_d;
  logic [AW-1:0]          k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]   x_q [TAPS];
  logic signed [DW-1:0]   x_d [TAPS];
  logic signed [DW-1:0]   w_q [TAPS];
  logic signed [DW-1:0]   w_d [TAPS];
  logic signed [DW-1:0]   d_q, d_d;
  logic signed [DW-1:0]   mu_q, mu_d;
  logic                   adapt_q, adapt_d;
  logic signed [DW-1:0]   g_q, g_d;
  logic signed [DW-1:0]   y_q, y_d;
  logic signed [DW-1:0]   err_q, err_d;
  logic                   out_valid_q, out_valid_d;

  logic signed [DW-1:0]   mac_a, mac_b;
  logic signed [2*DW-1:0] mac_prod;
  logic signed [DW-1:0]   mac_sat;
  logic signed [DW-1:0]   y_val, e_val;
  logic signed [DW:0]     e_wide;
  logic signed [WW-1:0]   w_sum;
  logic signed [DW-1:0]   w_upd;
  logic                   accept, last_k, done_hs;

  lms_mac_sat #(.DW(DW), .FRAC(FRAC)) u_mac (
    .a_i        (mac_a),
    .b_i        (mac_b),
    .prod_o     (mac_prod),
    .prod_sat_o (mac_sat)
  );

  assign bus.in_ready   = (state_q == IDLE) && !bus.clear_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.y_out      = y_q;
  assign bus.err_out    = err_q;
  assign bus.coef_rdata = w_q[bus.coef_addr];

  assign accept  = bus.in_valid && bus.in_ready;
  assign last_k  = (k_q == AW'(TAPS - 1));
  assign done_hs = out_valid_q && bus.out_ready;

  // Output and error terms derived from the finished accumulator (used in ERR).
  always_comb begin
    y_val  = DW'(sat(64'(acc_q >>> FRAC), DW));
    e_wide = (DW + 1)'(d_q) - (DW + 1)'(y_val);
    e_val  = DW'(sat(64'(e_wide), DW));
  end

  // New value for coefficient k from the current update product (used in UPDATE).
  always_comb begin
`ifdef LMS_LEAKAGE_EN
    w_sum = WW'(w_q[k_q]) - WW'(w_q[k_q] >>> LEAK_SHIFT) + WW'(mac_sat);
`else
    w_sum = WW'(w_q[k_q]) + WW'(mac_sat);
`endif
    w_upd = DW'(sat(64'(w_sum), DW));
  end

  // FSM next state, multiplier operand selection and datapath updates.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    x_d         = x_q;
    w_d         = w_q;
    d_d         = d_q;
    mu_d        = mu_q;
    adapt_d     = adapt_q;
    g_d         = g_q;
    y_d         = y_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    mac_a       = w_q[k_q];
    mac_b       = x_q[k_q];

    case (state_q)
      IDLE: begin
        if (bus.clear_w) begin
          for (int i = 0; i < TAPS; i++) w_d[i] = '0;
        end else if (accept) begin
          for (int i = TAPS - 1; i > 0; i--) x_d[i] = x_q[i-1];
          x_d[0]  = bus.x_in;
          d_d     = bus.d_in;
          mu_d    = bus.mu_in;
          adapt_d = bus.adapt_en;
          acc_d   = '0;
          k_d     = '0;
          state_d = FILTER;
        end
      end
      FILTER: begin
        acc_d = acc_q + ACCW'(mac_prod);
        if (last_k) begin
          k_d     = '0;
          state_d = ERR;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      ERR: begin
        mac_a   = mu_q;
        mac_b   = e_val;
        y_d     = y_val;
        err_d   = e_val;
        g_d     = mac_sat;
        state_d = adapt_q ? UPDATE : DONE;
      end
      UPDATE: begin
        mac_a       = g_q;
        w_d[k_q]    = w_upd;
        if (last_k) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      DONE: begin
        // out_valid follows DONE by one edge and drops on the handshake.
        out_valid_d = !done_hs;
        if (done_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation and zeroes everything.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      d_q         <= '0;
      mu_q        <= '0;
      adapt_q     <= 1'b0;
      g_q         <= '0;
      y_q         <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      d_q         <= d_d;
      mu_q        <= mu_d;
      adapt_q     <= adapt_d;
      g_q         <= g_d;
      y_q         <= y_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      w_q         <= w_d;
    end
  end
endmodule

// File: tb/tb_lms_adapt_serial.sv
// Directed plus randomized bench for lms_adapt_serial (DW=16, FRAC=12, TAPS=4)
// against a bit-true arithmetic model of the LMS recursion.
module tb_lms_adapt_serial;
  localparam int DW   = 16;
  localparam int FRAC = 12;
  localparam int T    = 4;
  localparam int LEAK = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  lms_adapt_serial_if #(.DW(DW), .TAPS(T)) bus ();

  lms_adapt_serial #(.DW(DW), .FRAC(FRAC), .TAPS(T), .LEAK_SHIFT(LEAK)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int mx [T];
  int mw [T];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < T; k++) begin
      mx[k] = 0;
      mw[k] = 0;
    end
  endfunction

  // One sample through the LMS recursion: y = sum w*x, e = d - y, w += mu*e*x.
  function automatic void model_step(input int xi, input int di, input int mui, input bit ad,
                                     output int y, output int e);
    longint acc;
    int g, upd;
    for (int k = T - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = xi;
    acc = 0;
    for (int k = 0; k < T; k++) acc += longint'(mw[k]) * longint'(mx[k]);
    y = sat16(acc >>> FRAC);
    e = sat16(longint'(di) - longint'(y));
    g = sat16((longint'(mui) * longint'(e)) >>> FRAC);
    if (ad) begin
      for (int k = 0; k < T; k++) begin
        upd = sat16((longint'(g) * longint'(mx[k])) >>> FRAC);
`ifdef LMS_LEAKAGE_EN
        mw[k] = sat16(longint'(mw[k]) - longint'(mw[k] >>> LEAK) + longint'(upd));
`else
        mw[k] = sat16(longint'(mw[k]) + longint'(upd));
`endif
      end
    end
  endfunction

  task automatic check_coefs(input string tag);
    for (int a = 0; a < T; a++) begin
      bus.coef_addr = 2'(a);
      #1;
      chk($sformatf("%s_w%0d", tag, a), bus.coef_rdata, mw[a]);
    end
  endtask

  task automatic pulse_reset();
    @(posedge Clk);
    #3 Rst = 1'b1;
    model_reset();
    repeat (3) @(posedge Clk);
    #3 Rst = 1'b0;
  endtask

  // Offer one sample, measure latency, check result, optionally stall, then handshake.
  task automatic do_sample(input int xi, input int di, input int mui, input bit ad,
                           input int hold, input bit clr_in_done, input string tag);
    int ey, ee, guard, lat;
    logic signed [DW-1:0] y0, e0;
    model_step(xi, di, mui, ad, ey, ee);
    @(negedge Clk);
    bus.x_in     = 16'(xi);
    bus.d_in     = 16'(di);
    bus.mu_in    = 16'(mui);
    bus.adapt_en = ad;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 50) chk({tag, "_ready_timeout"}, 0, 1);
    @(posedge Clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge Clk);
      #1 lat++;
      if (bus.out_valid) break;
    end
    chk({tag, "_lat"}, lat, ad ? 2 * T + 2 : T + 2);
    chk({tag, "_y"}, bus.y_out, ey);
    chk({tag, "_err"}, bus.err_out, ee);
    y0 = bus.y_out;
    e0 = bus.err_out;
    for (int i = 0; i < hold; i++) begin
      bus.clear_w = clr_in_done;
      @(posedge Clk);
      #1;
      chk({tag, "_hold_vld"}, bus.out_valid, 1);
      chk({tag, "_hold_y"}, bus.y_out, y0);
      chk({tag, "_hold_err"}, bus.err_out, e0);
      chk({tag, "_hold_rdy"}, bus.in_ready, 0);
    end
    bus.clear_w   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge Clk);
    #1 bus.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, bus.out_valid, 0);
  endtask

  initial begin
    int s, d, ok;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.d_in      = '0;
    bus.mu_in     = '0;
    bus.adapt_en  = 1'b0;
    bus.clear_w   = 1'b0;
    bus.out_ready = 1'b0;
    bus.coef_addr = '0;
    model_reset();

    // Reset state
    pulse_reset();
    #1;
    chk("rst_y", bus.y_out, 0);
    chk("rst_err", bus.err_out, 0);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_rdy", bus.in_ready, 1);
    check_coefs("rst");

    // Frozen adaptation: y=0, e=d, w untouched
    do_sample(16'h1000, 16'h0800, 16'h0333, 1'b0, 0, 1'b0, "freeze");
    check_coefs("freeze");

    // Single adapt step from a clean line: w0 = 0.2*1.0*1.0 = 0x0333
    pulse_reset();
    do_sample(16'h1000, 16'h1000, 16'h0333, 1'b1, 0, 1'b0, "adapt");
    chk("adapt_w0_const", mw[0], 32'sh0333);
    check_coefs("adapt");

    // Saturation: y = floor(0x333*0x7FFF/4096) = 0x1997, e = -32768-6551 clamps to 0x8000.
    // Output held 5 cycles with clear_w asserted in DONE (must be ignored).
    do_sample(16'h7FFF, -32768, 16'h0333, 1'b0, 5, 1'b1, "sat");
    chk("sat_err_const", bus.err_out, -32768);
    check_coefs("done_clear_ignored");

    // clear_w with in_valid in IDLE: clears w, no accept
    @(negedge Clk);
    bus.clear_w  = 1'b1;
    bus.in_valid = 1'b1;
    #1 chk("clr_rdy_low", bus.in_ready, 0);
    @(posedge Clk);
    #1;
    bus.clear_w  = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < T; k++) mw[k] = 0;
    check_coefs("clr");
    repeat (3) @(posedge Clk);
    #1;
    chk("clr_no_accept_rdy", bus.in_ready, 1);
    chk("clr_no_accept_vld", bus.out_valid, 0);

    // Random full-range samples (x line kept across the clear)
    for (int n = 0; n < 24; n++) begin
      do_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 32767)), 1'($urandom_range(0, 1)), 0, 1'b0, "rnd");
    end
    check_coefs("rnd");

    // Reset in the middle of UPDATE discards everything
    @(negedge Clk);
    bus.x_in = 16'h2000; bus.d_in = 16'h7000; bus.mu_in = 16'h4000;
    bus.adapt_en = 1'b1; bus.in_valid = 1'b1;
    @(posedge Clk);
    #1 bus.in_valid = 1'b0;
    repeat (T + 2) @(posedge Clk);
    #3 Rst = 1'b1;
    model_reset();
    #1;
    chk("abort_vld", bus.out_valid, 0);
    chk("abort_rdy", bus.in_ready, 1);
    repeat (2) @(posedge Clk);
    #3 Rst = 1'b0;
    check_coefs("abort");

    // Convergence towards the plant d = 0.5*(x0+x1+x2+x3)
    for (int n = 0; n < 2000; n++) begin
      int xi;
      xi = int'($urandom_range(0, 4096)) - 2048;
      s  = xi + mx[0] + mx[1] + mx[2];
      d  = s >>> 1;
      do_sample(xi, d, 16'h0333, 1'b1, 0, 1'b0, "conv");
    end
    check_coefs("conv");
    for (int a = 0; a < T; a++) begin
      bus.coef_addr = 2'(a);
      #1;
      // Floor quantisation of the update products biases settled weights slightly low.
`ifdef LMS_LEAKAGE_EN
      ok = (int'(bus.coef_rdata) >= 16'h0800 - 16'h0400) && (int'(bus.coef_rdata) <= 16'h0800 + 16'h0010);
`else
      ok = (int'(bus.coef_rdata) >= 16'h0800 - 16'h0040) && (int'(bus.coef_rdata) <= 16'h0800 + 16'h0040);
`endif
      chk($sformatf("conv_near_half_w%0d", a), ok, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
